// File: rtl/apb_initiator_pkg.sv
// Shared definitions for the APB initiator: 2-bit state encoding and
// default parameter values.
package apb_initiator_pkg;

  localparam int DEF_W_ADDR         = 16;
  localparam int DEF_W_DATA         = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_initiator.sv
// APB initiator: turns a valid/ready request into a single APB transfer
// and returns the result on a valid/ready response channel.
// Optional ACCESS-phase timeout is enabled by defining APB_INITIATOR_TIMEOUT_EN.
//
//   state  | meaning
//   IDLE   | ready for a request (req_ready=1)
//   SETUP  | psel=1, penable=0, one cycle
//   ACCESS | psel=1, penable=1, waiting for pready
//   RESP   | resp_valid=1, waiting for resp_ready
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int W_ADDR         = DEF_W_ADDR,
  parameter int W_DATA         = DEF_W_DATA,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [W_ADDR-1:0] req_addr,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [W_DATA-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_timeout,
  output logic              apbm_psel,
  output logic              apbm_penable,
  output logic              apbm_pwrite,
  output logic [W_ADDR-1:0] apbm_paddr,
  output logic [W_DATA-1:0] apbm_pwdata,
  input  logic [W_DATA-1:0] apbm_prdata,
  input  logic              apbm_pready,
  input  logic              apbm_pslverr
);

  apb_state_t        state_q, state_d;
  logic              cap_req, cap_resp, to_hit;
  logic              pwrite_q;
  logic [W_ADDR-1:0] paddr_q;
  logic [W_DATA-1:0] pwdata_q;
  logic [W_DATA-1:0] rdata_q;
  logic              err_q;

`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam int W_TO = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [W_TO-1:0] to_cnt_q;
  logic            timeout_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and capture strobes.
  always_comb begin
    state_d  = state_q;
    cap_req  = 1'b0;
    cap_resp = 1'b0;
    to_hit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          cap_req = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A completing pready on the terminal count takes priority over timeout.
        if (apbm_pready) begin
          cap_resp = 1'b1;
          state_d  = ST_RESP;
        end
`ifdef APB_INITIATOR_TIMEOUT_EN
        else if (to_cnt_q <= W_TO'(1)) begin
          to_hit  = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture (held on the bus until the transfer completes) and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (cap_req) begin
        pwrite_q <= req_write;
        paddr_q  <= req_addr;
        pwdata_q <= req_wdata;
      end
      if (cap_resp) begin
        rdata_q <= pwrite_q ? '0 : apbm_prdata;
        err_q   <= apbm_pslverr;
      end else if (to_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

`ifdef APB_INITIATOR_TIMEOUT_EN
  // Wait-cycle down-counter, reloaded in SETUP; timeout flag follows each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == ST_SETUP)
        to_cnt_q <= W_TO'(TIMEOUT_CYCLES);
      else if (state_q == ST_ACCESS && !apbm_pready && to_cnt_q != '0)
        to_cnt_q <= to_cnt_q - W_TO'(1);
      if (cap_resp)    timeout_q <= 1'b0;
      else if (to_hit) timeout_q <= 1'b1;
    end
  end
  assign resp_timeout = timeout_q;
`else
  assign resp_timeout = 1'b0;
`endif

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESP);
  assign apbm_psel    = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign apbm_penable = (state_q == ST_ACCESS);
  assign apbm_pwrite  = pwrite_q;
  assign apbm_paddr   = paddr_q;
  assign apbm_pwdata  = pwdata_q;
  assign resp_rdata   = rdata_q;
  assign resp_err     = err_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed scenarios plus randomized transfers,
// expectations from a transaction-level model of the APB protocol.
module tb_apb_initiator;

  localparam int T = 8;
`ifdef APB_INITIATOR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err, resp_timeout;
  logic [31:0] resp_rdata;
  logic        apbm_psel, apbm_penable, apbm_pwrite;
  logic [15:0] apbm_paddr;
  logic [31:0] apbm_pwdata;
  logic [31:0] apbm_prdata = '0;
  logic        apbm_pready = 1'b0, apbm_pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  apb_initiator #(.W_ADDR(16), .W_DATA(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout),
    .apbm_psel(apbm_psel), .apbm_penable(apbm_penable), .apbm_pwrite(apbm_pwrite),
    .apbm_paddr(apbm_paddr), .apbm_pwdata(apbm_pwdata), .apbm_prdata(apbm_prdata),
    .apbm_pready(apbm_pready), .apbm_pslverr(apbm_pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full transfer. Called at a negedge; returns at the negedge after the
  // response handshake (DUT back in IDLE). waits = pready-low cycles in ACCESS.
  task automatic do_txn(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input bit serr,
                        input int hold, input bit keep_valid, input bit expect_now);
    int cyc, acc, exp_acc;
    bit exp_to, exp_err;
    logic [31:0] exp_rd;
    // transaction-level expectation
    if (TO_EN && waits + 1 > T) begin
      exp_acc = T; exp_to = 1'b1; exp_err = 1'b1; exp_rd = '0;
    end else begin
      exp_acc = waits + 1; exp_to = 1'b0; exp_err = serr; exp_rd = wr ? 32'h0 : rd;
    end

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    cyc = 0;
    while (!req_ready && cyc < 50) begin
      @(negedge clk); cyc++;
    end
    if (expect_now) chk("accept_immediate", 32'(cyc), 32'd0);
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(negedge clk);  // SETUP
    req_valid = keep_valid ? 1'b1 : 1'($urandom % 2);
    apbm_pready = 1'($urandom % 2); apbm_pslverr = 1'($urandom % 2); apbm_prdata = $urandom;
    chk("setup_psel", {30'd0, apbm_psel, apbm_penable}, 32'h2);
    chk("setup_bus", {apbm_pwrite, 15'd0, apbm_paddr}, {wr, 15'd0, addr});
    chk("setup_pwdata", apbm_pwdata, wd);
    chk("setup_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);  // first ACCESS cycle
    chk("access_penable", {30'd0, apbm_psel, apbm_penable}, 32'h3);
    acc = 0;
    while (apbm_psel && apbm_penable && acc < 300) begin
      acc++;
      if (apbm_paddr !== addr || apbm_pwdata !== wd || apbm_pwrite !== wr || req_ready !== 1'b0)
        chk("access_stable", {apbm_pwrite, req_ready, 14'd0, apbm_paddr}, {wr, 15'd0, addr});
      req_valid = keep_valid ? 1'b1 : 1'($urandom % 2);
      if (acc == waits + 1) begin
        apbm_pready = 1'b1; apbm_prdata = rd; apbm_pslverr = serr;
      end else begin
        apbm_pready = 1'b0; apbm_prdata = $urandom; apbm_pslverr = 1'($urandom % 2);
      end
      @(negedge clk);
    end
    req_valid = keep_valid;
    chk("access_cycles", 32'(acc), 32'(exp_acc));
    for (int i = 0; i <= hold; i++) begin
      resp_ready = (i == hold);
      apbm_pready = 1'($urandom % 2); apbm_prdata = $urandom; apbm_pslverr = 1'($urandom % 2);
      chk("resp_flags", {28'd0, resp_valid, req_ready, apbm_psel, apbm_penable}, 32'h8);
      chk("resp_rdata", resp_rdata, exp_rd);
      chk("resp_err_to", {30'd0, resp_err, resp_timeout}, {30'd0, exp_err, exp_to});
      @(negedge clk);
    end
    resp_ready = 1'b0;
    chk("post_hs", {30'd0, resp_valid, req_ready}, 32'h1);
    chk("post_hs_rdata", resp_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outputs", {27'd0, apbm_psel, apbm_penable, apbm_pwrite, resp_valid, resp_timeout}, 32'd0);
    chk("rst_addr_data", {apbm_paddr, 16'd0} | 32'(resp_err), 32'd0);
    chk("rst_pwdata", apbm_pwdata, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);

    // zero-wait write
    do_txn(1'b1, 16'h0000, 32'h0000_0048, 0, 32'h0, 1'b0, 0, 1'b0, 1'b1);
    // read with 3 wait states
    do_txn(1'b0, 16'h0004, 32'h1234_5678, 3, 32'hDEAD_BEEF, 1'b0, 1, 1'b0, 1'b1);
    // slave error, response back-pressured for 5 cycles
    do_txn(1'b1, 16'h0010, 32'hCAFE_F00D, 1, 32'h0, 1'b1, 5, 1'b0, 1'b1);
    // long wait: times out when enabled, otherwise completes normally
    do_txn(1'b0, 16'h0020, 32'h0, 20, 32'h5555_AAAA, 1'b0, 0, 1'b0, 1'b1);
    // pready arriving on the terminal wait cycle
    do_txn(1'b0, 16'h0024, 32'h0, T - 1, 32'h0BAD_F00D, 1'b0, 0, 1'b0, 1'b1);
    // back-to-back: req_valid held high across both requests
    do_txn(1'b1, 16'h0100, 32'h1111_1111, 2, 32'h0, 1'b0, 2, 1'b1, 1'b1);
    do_txn(1'b0, 16'h0104, 32'h0, 0, 32'h2222_2222, 1'b0, 0, 1'b0, 1'b1);

    // reset during ACCESS
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0ABC; req_wdata = '0;
    @(negedge clk);
    req_valid = 1'b0; apbm_pready = 1'b0;
    @(negedge clk);
    chk("pre_rst_access", {30'd0, apbm_psel, apbm_penable}, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_bus", {29'd0, apbm_psel, apbm_penable, resp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apbm_pready = 1'b1; apbm_prdata = 32'hFFFF_FFFF;
    chk("rst_release", {29'd0, req_ready, resp_valid, apbm_psel}, 32'h4);
    chk("rst_paddr", 32'(apbm_paddr), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_resp", {30'd0, resp_valid, apbm_psel}, 32'd0);
    end
    apbm_pready = 1'b0;

    // randomized transfers
    for (int n = 0; n < 25; n++) begin
      automatic bit          wr = 1'($urandom % 2);
      automatic logic [15:0] ad = 16'($urandom);
      automatic logic [31:0] wd = $urandom;
      automatic logic [31:0] rd = $urandom;
      automatic int          wt = $urandom_range(0, 5);
      automatic bit          se = ($urandom_range(0, 3) == 0);
      automatic int          hd = $urandom_range(0, 3);
      automatic int          gap = $urandom_range(0, 2);
      do_txn(wr, ad, wd, wt, rd, se, hd, 1'b0, 1'b1);
      for (int g = 0; g < gap; g++) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_initiator.md
APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 SHALL have parameter W_ADDR, default 16, APB address width.
REQ-002 SHALL have parameter W_DATA, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS-phase wait cycles (used only with APB_INITIATOR_TIMEOUT_EN).
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports req_valid input 1, req_ready output 1, req_write input 1, req_addr input W_ADDR, req_wdata input W_DATA: request channel, valid/ready handshake.
REQ-007 SHALL have ports resp_valid output 1, resp_ready input 1, resp_rdata output W_DATA, resp_err output 1, resp_timeout output 1: response channel.
REQ-008 SHALL have APB initiator ports apbm_psel, apbm_penable, apbm_pwrite (output 1), apbm_paddr (output W_ADDR), apbm_pwdata (output W_DATA), apbm_prdata (input W_DATA), apbm_pready, apbm_pslverr (input 1).

Function
REQ-009 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP.
REQ-010 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready.
REQ-011 SHALL, on acceptance, register write/addr/wdata and enter SETUP next cycle; captured values SHALL be held on apbm_pwrite/paddr/pwdata, unchanged, until the transfer leaves ACCESS.
REQ-012 SHALL in SETUP drive psel=1, penable=0, and unconditionally enter ACCESS next cycle.
REQ-013 SHALL in ACCESS drive psel=1, penable=1; stay in ACCESS while pready=0.
REQ-014 SHALL, on pready=1 in ACCESS, capture prdata (reads only; writes capture 0) and pslverr into resp_rdata/resp_err, and enter RESP next cycle with psel=penable=0.
REQ-015 SHALL in RESP hold resp_valid=1 and response fields stable until resp_ready=1, then return to IDLE next cycle.
REQ-016 SHALL give minimum latency: acceptance at cycle N, SETUP N+1, ACCESS N+2, resp_valid N+3 with zero wait states.
REQ-017 SHALL ignore req_valid and all APB inputs outside the states where they are sampled.
REQ-018 SHALL drive resp_valid=0 outside RESP; resp fields SHALL retain last captured value.

Reset
REQ-019 SHALL on rst_n low force IDLE, with psel, penable, pwrite, paddr, pwdata, resp_valid, resp_rdata, resp_err, resp_timeout all 0, and req_ready=1 on first cycle after release.
REQ-020 SHALL abandon any in-flight transfer on reset without producing a response.

Configuration
REQ-021 SHALL, with APB_INITIATOR_TIMEOUT_EN defined, count ACCESS cycles with pready=0; on count reaching TIMEOUT_CYCLES, enter RESP with resp_err=1, resp_timeout=1, resp_rdata=0, psel/penable deasserted.
REQ-022 SHALL reset the timeout counter on entry to SETUP; pready=1 on the terminal cycle SHALL win over timeout.
REQ-023 SHALL, without APB_INITIATOR_TIMEOUT_EN, omit the counter, wait indefinitely in ACCESS, and tie resp_timeout to 0.

Structure
REQ-024 SHALL place FSM state encoding (2-bit) and default parameter constants in shared package apb_initiator_pkg.
REQ-025 SHALL be a single module; no sub-module required.

Verification
REQ-026 Write addr 0x0000 data 0x00000048, pready=1 immediately -> psel at N+1, penable at N+2, resp_valid at N+3, resp_err=0.
REQ-027 Read addr 0x0004, pready low 3 cycles then high with prdata 0xDEADBEEF -> ACCESS lasts 4 cycles, resp_rdata=0xDEADBEEF.
REQ-028 Write with pslverr=1 at completion -> resp_err=1, resp_timeout=0; resp_ready held low 5 cycles -> resp_valid and fields stable, req_ready=0 throughout.
REQ-029 Macro defined, TIMEOUT_CYCLES=8, pready never asserted -> RESP after 8 ACCESS wait cycles, resp_err=1, resp_timeout=1, resp_rdata=0.
REQ-030 rst_n asserted during ACCESS -> psel/penable 0 immediately, no resp_valid, req_ready=1 after release.
REQ-031 req_valid asserted continuously for 2 requests -> second accepted only the cycle after first response handshake.
